// File: rtl/data_memory_responder.sv
// data_memory_responder
// Memory-side responder for the core's data-memory access stage. One request
// is accepted per enable_memaccess strobe while idle. It runs WAIT_CYCLES wait
// states and completes against a word-organised synchronous array. It then
// pulses DM_ready for one cycle.
//
// Optional feature macro: DM_ALIGN_CHECK_EN
//   defined   : misaligned, out-of-range, or read+write requests complete with
//               DM_error=1 and no array or DM_out update.
//   undefined : DM_error is tied low, low address bits are ignored, upper bits
//               wrap modulo the array depth, and write wins over read.
//
// Handshake: a request is taken on a rising edge where the responder is IDLE,
// enable_memaccess=1 and (DM_read|DM_write)=1. DM_busy stays high from the
// cycle after that edge up to and including the DM_ready cycle. Strobes seen
// while busy are dropped.
// fsm_state exposes the state register for debug and checker binding.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_memaccess,
  input  logic        DM_read,
  input  logic        DM_write,
  input  logic [31:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        DM_ready,
  output logic        DM_busy,
  output logic        DM_error,
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic accept;
  logic req_err;

  // Operation captured at accept; the in-flight access uses only these.
  logic                  op_read, op_write, op_err;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [31:0]           op_data;

  // Effective operation for the edge that enters RESP. With zero wait states
  // that edge is the accept edge itself, so the live inputs are used.
  logic                  eff_read, eff_write, eff_err;
  logic [ADDR_WIDTH-1:0] eff_idx;
  logic [31:0]           eff_data;
  logic                  enter_resp;
  logic                  do_write;
  logic                  do_read;

  logic [31:0] mem [DEPTH];

`ifdef DM_ALIGN_CHECK_EN
  assign req_err = (DM_address[1:0] != 2'b00) ||
                   (DM_address[31:ADDR_WIDTH+2] != '0) ||
                   (DM_read && DM_write);
`else
  logic unused_addr;
  assign req_err     = 1'b0;
  assign unused_addr = ^{DM_address[31:ADDR_WIDTH+2], DM_address[1:0]};
`endif

  // Next-state and counter logic; accept qualifies a request only in IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable_memaccess && (DM_read || DM_write)) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Select live inputs on the accept edge, latched values afterwards.
  always_comb begin
    eff_read  = op_read;
    eff_write = op_write;
    eff_err   = op_err;
    eff_idx   = op_idx;
    eff_data  = op_data;
    if (accept) begin
      eff_read  = DM_read;
      eff_write = DM_write;
      eff_err   = req_err;
      eff_idx   = DM_address[ADDR_WIDTH+1:2];
      eff_data  = DM_in;
    end
  end

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);
  // Gated by reset so an access can never land while reset is asserted.
  assign do_write   = reset && enter_resp && eff_write && !eff_err;
  assign do_read    = enter_resp && eff_read && !eff_write && !eff_err;

  // State register, wait counter and captured operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      op_read  <= 1'b0;
      op_write <= 1'b0;
      op_err   <= 1'b0;
      op_idx   <= '0;
      op_data  <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        op_read  <= DM_read;
        op_write <= DM_write;
        op_err   <= req_err;
        op_idx   <= DM_address[ADDR_WIDTH+1:2];
        op_data  <= DM_in;
      end
    end
  end

  // Registered response outputs, derived from the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DM_ready <= 1'b0;
      DM_busy  <= 1'b0;
      DM_error <= 1'b0;
    end else begin
      DM_ready <= (state_next == S_RESP);
      DM_busy  <= (state_next != S_IDLE);
      DM_error <= enter_resp && eff_err;
    end
  end

  // Read data register; holds its value until the next successful read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DM_out <= 32'd0;
    end else if (do_read) begin
      DM_out <= mem[eff_idx];
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[eff_idx] <= eff_data;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder. It uses three instances with
// WAIT_CYCLES 0, 2 and 3. They share the data/address/op lines and each has
// its own strobe.
module tb_data_memory_responder;

  logic        clock;
  logic        reset;
  logic [2:0]  en_a;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0][31:0] out_a;
  logic [2:0]       rdy_a;
  logic [2:0]       busy_a;
  logic [2:0]       err_a;
  logic [2:0][1:0]  st_a;

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES((g == 0) ? 0 : g + 1)
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .enable_memaccess(en_a[g]),
      .DM_read         (rd),
      .DM_write        (wr),
      .DM_address      (addr),
      .DM_in           (din),
      .DM_out          (out_a[g]),
      .DM_ready        (rdy_a[g]),
      .DM_busy         (busy_a[g]),
      .DM_error        (err_a[g]),
      .fsm_state       (st_a[g])
    );
  end

  function automatic int wc_of(input int i);
    return (i == 0) ? 0 : i + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access on instance idx. Samples every negedge from the cycle that
  // starts at the accept edge (n=1) to two cycles past the expected response.
  // inject_n>0 strobes a write of 0x22222222 to 0x20 during cycle inject_n.
  task automatic access(input int idx, input logic t_rd, input logic t_wr,
                        input logic [31:0] t_addr, input logic [31:0] t_data,
                        input logic exp_err, input logic chk_out,
                        input logic [31:0] exp_out, input int inject_n,
                        input string tag);
    int lat;
    int first;
    int pulses;
    int busy_cnt;
    lat      = wc_of(idx);
    first    = 0;
    pulses   = 0;
    busy_cnt = 0;
    @(negedge clock);
    rd        = t_rd;
    wr        = t_wr;
    addr      = t_addr;
    din       = t_data;
    en_a[idx] = 1'b1;
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clock);
      if (n == 1) begin
        en_a[idx] = 1'b0;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = 32'hFFFF_FFFF;
        din  = 32'h0;
      end
      if (n == inject_n) begin
        en_a[idx] = 1'b1;
        wr   = 1'b1;
        addr = 32'h20;
        din  = 32'h2222_2222;
      end else if (inject_n > 0 && n == inject_n + 1) begin
        en_a[idx] = 1'b0;
        wr = 1'b0;
      end
      if (rdy_a[idx]) begin
        pulses++;
        if (first == 0) first = n;
        check({tag, "_err"}, 32'(err_a[idx]), 32'(exp_err));
        if (chk_out) check({tag, "_out"}, out_a[idx], exp_out);
      end
      if (busy_a[idx]) busy_cnt++;
    end
    check({tag, "_lat"}, 32'(first), 32'(lat + 1));
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_busy"}, 32'(busy_cnt), 32'(lat + 1));
    check({tag, "_idle"}, 32'(st_a[idx]), 32'd0);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    reset = 1'b0;
    en_a  = 3'b000;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 32'h0;
    din   = 32'h0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("rst_out", out_a[i], 32'h0);
      check("rst_flags", {29'd0, rdy_a[i], busy_a[i], err_a[i]}, 32'h0);
      check("rst_state", 32'(st_a[i]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);

    // WAIT_CYCLES=2: write then read back
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0, "w2_wr10");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, "w2_rd10");

    // WAIT_CYCLES=0: one-cycle latency, busy for exactly one cycle
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0, "w0_wr10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, "w0_rd10");

    // strobe with neither read nor write is ignored
    @(negedge clock);
    en_a[0] = 1'b1;
    @(negedge clock);
    en_a[0] = 1'b0;
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      if (rdy_a[0] || busy_a[0]) pulses++;
      @(negedge clock);
    end
    check("w0_noop", 32'(pulses), 32'd0);

    // read and write together: write wins, DM_out holds the last read value
`ifdef DM_ALIGN_CHECK_EN
    access(0, 1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, "w0_both");
`else
    access(0, 1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, "w0_both");
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 0, "w0_rd40");
`endif

    // strobe while busy is ignored; word 0x20 keeps its value
    access(1, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 0, "w2_wr20");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, "w2_busy_strobe");
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 0, "w2_rd20");

    // WAIT_CYCLES=3: reset in WAIT discards the pending write
    access(2, 1'b0, 1'b1, 32'h30, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 0, "w3_wr30");
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 0, "w3_rd30");
    @(negedge clock);
    en_a[2] = 1'b1;
    wr   = 1'b1;
    addr = 32'h30;
    din  = 32'h1234_5678;
    @(negedge clock);
    en_a[2] = 1'b0;
    wr = 1'b0;
    check("w3_in_wait", 32'(st_a[2]), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("w3_rst_out", out_a[2], 32'h0);
    check("w3_rst_flags", {29'd0, rdy_a[2], busy_a[2], err_a[2]}, 32'h0);
    check("w3_rst_state", 32'(st_a[2]), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 0, "w3_rd30_after_rst");

    // misaligned byte address and upper-bit wrap
`ifdef DM_ALIGN_CHECK_EN
    access(1, 1'b0, 1'b1, 32'h12, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 0, "w2_wr12");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, "w2_rd10_kept");
    access(1, 1'b0, 1'b1, 32'h1004, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0, 0, "w2_wr1004");
`else
    access(1, 1'b0, 1'b1, 32'h12, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 0, "w2_wr12");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 0, "w2_rd10_mis");
    access(1, 1'b0, 1'b1, 32'h1004, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 0, "w2_wr1004");
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5, 0, "w2_rd4_wrap");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the multicycle core's data-memory access stage: the other end of the DM_read/DM_write request lines the core drives during its memory-access stage. It accepts one request per enable_memaccess strobe and latches the address, data and operation. It then runs a programmable number of wait states and completes the access against an internal word-organised synchronous array. It returns read data with a one-cycle DM_ready pulse, and DM_busy lets the core stall its stage sequencer when wait states exceed the stage slack.

## Interface
- ADDR_WIDTH, 10: word-address width; array depth is 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 1: wait states between accept and response; legal range 0..15.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable_memaccess  input  1  request strobe; sampled only in IDLE.
- DM_read  input  1  read request, qualified by enable_memaccess.
- DM_write  input  1  write request, qualified by enable_memaccess.
- DM_address  input  32  byte address; word index = DM_address[ADDR_WIDTH+1:2].
- DM_in  input  32  write data.
- DM_out  output  32  read data; valid while DM_ready=1, held until the next read completes.
- DM_ready  output  1  one-cycle completion pulse.
- DM_busy  output  1  high in WAIT and RESP.
- DM_error  output  1  valid with DM_ready; request rejected.

## Operation
- States:
  - IDLE: waits for a request.
  - WAIT: counts wait states with a 4-bit down-counter.
  - RESP: asserts the response for one cycle.
- IDLE, enable_memaccess=1 and (DM_read|DM_write)=1 at a rising edge:
  - Latch the operation, DM_address and DM_in.
  - If WAIT_CYCLES>0: load the counter with WAIT_CYCLES-1 and go to WAIT.
  - If WAIT_CYCLES=0: go to RESP.
- IDLE, strobe with neither DM_read nor DM_write: ignored; stay in IDLE.
- WAIT: decrement the counter each cycle; at counter=0 go to RESP.
- Access is performed on the edge that enters RESP:
  - Write: array[index] <= latched data.
  - Read: DM_out <= array[index].
- RESP: DM_ready=1 for exactly one cycle, then return to IDLE.
- Strobes arriving in WAIT or RESP are ignored; no queueing.
- DM_read and DM_write both asserted at accept: write takes priority, DM_out is not updated, DM_error=0 (unless DM_ALIGN_CHECK_EN rejects it, see Configuration).
- Input changes after accept have no effect on the access in flight.
- Reset values: state=IDLE, counter=0, DM_out=0, DM_ready=0, DM_busy=0, DM_error=0, latched operation/address/data=0.
- The array is not reset; its contents are undefined after power-up.
- Reset asserted mid-access: return to IDLE immediately; a pending write is discarded and the array is unchanged.

## Timing
- Accept edge E. DM_ready is high during the cycle that starts WAIT_CYCLES+1 edges after E:
  - WAIT_CYCLES=0: DM_ready high in the cycle immediately after E.
  - WAIT_CYCLES=1: DM_ready high two cycles after E.
- DM_busy rises in the cycle after E and falls in the cycle after RESP.
- Earliest next accept is the first IDLE cycle after RESP; maximum throughput is one access per WAIT_CYCLES+2 cycles.
- DM_out, DM_ready, DM_busy and DM_error are registered; there is no combinational path from inputs to outputs.

## Configuration
- DM_ALIGN_CHECK_EN defined:
  - At accept, the request is flagged as an error if DM_address[1:0]!=0, if DM_address[31:ADDR_WIDTH+2]!=0, or if DM_read and DM_write are both set.
  - Flagged requests still take the full WAIT_CYCLES+1 latency.
  - In RESP they drive DM_ready=1 and DM_error=1, with no array write and DM_out unchanged.
- DM_ALIGN_CHECK_EN undefined:
  - DM_error is tied to 0.
  - DM_address[1:0] is ignored and upper address bits wrap modulo the array depth.
  - When both requests are set, write wins.

## Test plan
- WAIT_CYCLES=2: write 0xDEADBEEF at 0x10, then read 0x10 -> DM_ready exactly 3 cycles after each accept; read returns DM_out=0xDEADBEEF.
- WAIT_CYCLES=0: read at 0x10 -> DM_ready in the cycle after accept; DM_busy high for exactly 1 cycle.
- Strobe a write to 0x20 while DM_busy=1 -> ignored; word 0x20 unchanged; exactly one DM_ready pulse.
- Start a write of 0x12345678 to 0x30 with WAIT_CYCLES=3, assert reset low in WAIT -> all outputs 0; a later read of 0x30 returns the prior value.
- With DM_ALIGN_CHECK_EN: write to 0x12 -> DM_ready=1, DM_error=1, array unchanged. Without it: the same write lands in word index 4 (byte address 0x10).
- Without DM_ALIGN_CHECK_EN, ADDR_WIDTH=10: write 0xA5A5A5A5 to 0x1004, read 0x4 -> DM_out=0xA5A5A5A5 (wrap-around).
